// File: rtl/router_arb_pkg.sv
// Shared types and helpers for the queue output arbiter.
// rr_pick is written for up to MAX_IN requesters; callers zero-extend their
// request vector and pass the real requester count in n.
package router_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int unsigned MAX_IN    = 16;
    localparam int unsigned MAX_IDX_W = 4;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req at or after ptr, searching upward and wrapping at n.
    function automatic rr_pick_t rr_pick(input logic [MAX_IN-1:0] req,
                                         input int unsigned       ptr,
                                         input int unsigned       n);
        rr_pick_t    res;
        int unsigned j;
        res = '0;
        for (int unsigned k = 0; k < MAX_IN; k++) begin
            if (k < n && !res.found) begin
                j = ptr + k;
                if (j >= n) j = j - n;
                if (req[j[MAX_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = j[MAX_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/queue_output_arbiter_if.sv
// Bundle of the per-queue AXI-Stream inputs, queue status flags and the
// shared output link. master = arbiter side, slave = queues/link side.
interface queue_output_arbiter_if #(
    parameter  int unsigned NUM_IN     = 4,
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned IDX_W      = $clog2(NUM_IN)
) ();

    logic [NUM_IN-1:0]            in_tvalid;
    logic [NUM_IN-1:0]            in_tready;
    logic [NUM_IN*DATA_WIDTH-1:0] in_tdata;
    logic [NUM_IN-1:0]            in_tlast;
    logic [NUM_IN-1:0]            q_empty;
    logic [NUM_IN-1:0]            q_half_full;
    logic                         out_tvalid;
    logic                         out_tready;
    logic [DATA_WIDTH-1:0]        out_tdata;
    logic                         out_tlast;
    logic [IDX_W-1:0]             grant_idx;
    logic                         busy;

    modport master (
        input  in_tvalid, in_tdata, in_tlast, q_empty, q_half_full, out_tready,
        output in_tready, out_tvalid, out_tdata, out_tlast, grant_idx, busy
    );

    modport slave (
        output in_tvalid, in_tdata, in_tlast, q_empty, q_half_full, out_tready,
        input  in_tready, out_tvalid, out_tdata, out_tlast, grant_idx, busy
    );

endinterface

// File: rtl/queue_output_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: rotate the request vector by ptr and
// priority-encode the first set request.
module rr_priority_picker
    import router_arb_pkg::*;
#(
    parameter  int unsigned NUM_IN = 4,
    localparam int unsigned IDX_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              found,
    output logic [IDX_W-1:0]  idx
);

    logic [MAX_IN-1:0] req_ext;
    rr_pick_t          pick;
    logic              unused_pick_hi;

    // Widen to the helper's fixed width and pick the next requester.
    always_comb begin
        req_ext               = '0;
        req_ext[NUM_IN-1:0]   = req;
        pick                  = rr_pick(req_ext, 32'(ptr), NUM_IN);
        found                 = pick.found;
        idx                   = pick.idx[IDX_W-1:0];
        unused_pick_hi        = ^pick.idx[MAX_IDX_W-1:IDX_W];
    end

endmodule

// File: rtl/queue_output_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream output between
// NUM_IN queues. A grant is held from the first beat through TLAST.
// Optional build macro ARB_HALF_FULL_PRIO_EN: queues reporting half_full
// win IDLE arbitration ahead of the others.
module queue_output_arbiter
    import router_arb_pkg::*;
#(
    parameter  int unsigned NUM_IN     = 4,
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned IDX_W      = $clog2(NUM_IN)
) (
    input logic                   clk,
    input logic                   rst,
    queue_output_arbiter_if.master bus
);

    arb_state_t        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [NUM_IN-1:0] req;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic              last_beat;

    // A queue requests when it presents data and is not empty.
    always_comb req = bus.in_tvalid & ~bus.q_empty;

`ifdef ARB_HALF_FULL_PRIO_EN
    logic [NUM_IN-1:0] hi_req;
    logic              hi_found;
    logic [IDX_W-1:0]  hi_idx;
    logic              lo_found;
    logic [IDX_W-1:0]  lo_idx;

    // Half-full requesters form the high-priority set.
    always_comb hi_req = req & bus.q_half_full;

    rr_priority_picker #(.NUM_IN(NUM_IN)) u_pick_hi (
        .req   (hi_req),
        .ptr   (rr_ptr),
        .found (hi_found),
        .idx   (hi_idx)
    );

    rr_priority_picker #(.NUM_IN(NUM_IN)) u_pick_lo (
        .req   (req),
        .ptr   (rr_ptr),
        .found (lo_found),
        .idx   (lo_idx)
    );

    // Fall back to the plain search only when no half-full queue requests.
    always_comb begin
        pick_found = hi_found | lo_found;
        pick_idx   = hi_found ? hi_idx : lo_idx;
    end
`else
    logic unused_half_full;

    // Half-full status does not influence arbitration in this build.
    always_comb unused_half_full = ^bus.q_half_full;

    rr_priority_picker #(.NUM_IN(NUM_IN)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );
`endif

    // Pass the granted queue straight through while a packet is locked.
    always_comb begin
        bus.out_tvalid = 1'b0;
        bus.out_tdata  = '0;
        bus.out_tlast  = 1'b0;
        bus.in_tready  = '0;
        if (state == LOCK) begin
            bus.out_tvalid               = bus.in_tvalid[bus.grant_idx];
            bus.out_tdata                = bus.in_tdata[bus.grant_idx*DATA_WIDTH +: DATA_WIDTH];
            bus.out_tlast                = bus.in_tlast[bus.grant_idx];
            bus.in_tready[bus.grant_idx] = bus.out_tready;
        end
    end

    always_comb last_beat = bus.out_tvalid & bus.out_tready & bus.out_tlast;

    // Arbitration FSM: grant in IDLE, release after the TLAST beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            bus.grant_idx <= '0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state         <= LOCK;
                        bus.grant_idx <= pick_idx;
                        bus.busy      <= 1'b1;
                    end
                end
                LOCK: begin
                    if (last_beat) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        rr_ptr   <= (bus.grant_idx == IDX_W'(NUM_IN - 1)) ? '0
                                                                          : bus.grant_idx + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_queue_output_arbiter.sv
// Scoreboard bench for queue_output_arbiter: directed packets are loaded into
// per-queue source models, expected output beats are queued in hand-computed
// order, and a monitor compares every accepted output beat.
module tb_queue_output_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    queue_output_arbiter_if #(.NUM_IN(N), .DATA_WIDTH(DW)) bus ();

    queue_output_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          tests = 0;
    int          fails = 0;
    int          xfers = 0;
    int          x0;
    logic [32:0] srcq [N][$];
    logic [34:0] expq [$];
    logic [N-1:0] stall = '0;
    logic [N-1:0] fire;
    logic        gap_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [34:0] pk(input int q, input logic last, input logic [31:0] d);
        logic [1:0] qq;
        qq = q[1:0];
        return {qq, last, d};
    endfunction

    task automatic load(input int q, input logic [31:0] d0, input int n);
        logic [31:0] d;
        for (int k = 0; k < n; k++) begin
            d = d0 + 32'(k);
            srcq[q].push_back({(k == n - 1), d});
        end
    endtask

    task automatic expect_pkt(input int q, input logic [31:0] d0, input int n);
        for (int k = 0; k < n; k++) expq.push_back(pk(q, (k == n - 1), d0 + 32'(k)));
    endtask

    task automatic drive();
        logic [32:0] b;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() != 0) begin
                b = srcq[i][0];
                bus.in_tvalid[i]          = !stall[i];
                bus.in_tdata[i*DW +: DW]  = b[31:0];
                bus.in_tlast[i]           = b[32];
                bus.q_empty[i]            = 1'b0;
            end else begin
                bus.in_tvalid[i]          = 1'b0;
                bus.in_tdata[i*DW +: DW]  = '0;
                bus.in_tlast[i]           = 1'b0;
                bus.q_empty[i]            = 1'b1;
            end
        end
    endtask

    // One clock: capture handshakes, let the edge happen, pop sources, end at negedge.
    task automatic step();
        #1;
        fire = bus.in_tvalid & bus.in_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (fire[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
        drive();
        @(negedge clk);
    endtask

    function automatic bit pending();
        bit p;
        p = (expq.size() != 0);
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input string name, input bit toggle);
        int budget;
        budget = 0;
        while (pending() && budget < 200) begin
            if (toggle) bus.out_tready = ~bus.out_tready;
            step();
            budget++;
        end
        bus.out_tready = 1'b1;
        check({name, "_drained"}, 64'(expq.size()), 64'd0);
    endtask

    // Monitor: every accepted output beat must match the head of the scoreboard,
    // and the cycle after a TLAST beat must be an idle bubble.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            gap_pending = 1'b0;
        end else begin
            if (gap_pending) begin
                check("bubble_busy", 64'(bus.busy), 64'd0);
                gap_pending = 1'b0;
            end
            if (bus.out_tvalid && bus.out_tready) begin
                xfers++;
                if (expq.size() == 0)
                    check("unexpected_beat", 64'({bus.grant_idx, bus.out_tlast, bus.out_tdata}), 64'd0);
                else
                    check("beat", 64'({bus.grant_idx, bus.out_tlast, bus.out_tdata}), 64'(expq.pop_front()));
                if (bus.out_tlast) gap_pending = 1'b1;
            end
        end
    end

    initial begin
        rst             = 1'b1;
        bus.out_tready  = 1'b1;
        bus.q_half_full = '0;
        drive();

        // Reset with every queue valid, then one single-beat packet each.
        for (int q = 0; q < N; q++) begin
            load(q, 32'h10 + 32'(q), 1);
            expect_pkt(q, 32'h10 + 32'(q), 1);
        end
        drive();
        step();
        step();
        check("reset_in_tready", 64'(bus.in_tready), 64'd0);
        check("reset_out_tvalid", 64'(bus.out_tvalid), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_grant_idx", 64'(bus.grant_idx), 64'd0);
        rst = 1'b0;
        step();
        check("first_grant_busy", 64'(bus.busy), 64'd1);
        check("first_grant_idx", 64'(bus.grant_idx), 64'd0);
        check("first_out_tvalid", 64'(bus.out_tvalid), 64'd1);
        drain("t1_rr", 1'b0);

        // Queues 0 and 2 with 3-beat packets.
        load(0, 32'hA0, 3);
        load(2, 32'hC0, 3);
        expect_pkt(0, 32'hA0, 3);
        expect_pkt(2, 32'hC0, 3);
        drive();
        drain("t2_two_pkts", 1'b0);

        // Queue 1 stalls mid-packet while queue 3 waits.
        load(1, 32'hB0, 4);
        expect_pkt(1, 32'hB0, 4);
        expect_pkt(3, 32'hD0, 1);
        drive();
        step();
        check("t3_busy", 64'(bus.busy), 64'd1);
        check("t3_grant", 64'(bus.grant_idx), 64'd1);
        load(3, 32'hD0, 1);
        drive();
        step();
        stall[1] = 1'b1;
        drive();
        for (int s = 0; s < 2; s++) begin
            step();
            check("t3_stall_grant", 64'(bus.grant_idx), 64'd1);
            check("t3_stall_busy", 64'(bus.busy), 64'd1);
            check("t3_stall_out_tvalid", 64'(bus.out_tvalid), 64'd0);
        end
        stall[1] = 1'b0;
        drive();
        drain("t3_stall", 1'b0);

        // out_tready toggling during a 4-beat packet.
        x0 = xfers;
        load(0, 32'hE0, 4);
        expect_pkt(0, 32'hE0, 4);
        drive();
        drain("t4_toggle", 1'b1);
        check("t4_xfer_count", 64'(xfers - x0), 64'd4);

        // All four queues requesting, single-beat packets: 0,1,2,3,0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        load(0, 32'h50, 1);
        load(0, 32'h54, 1);
        load(1, 32'h51, 1);
        load(2, 32'h52, 1);
        load(3, 32'h53, 1);
        expect_pkt(0, 32'h50, 1);
        expect_pkt(1, 32'h51, 1);
        expect_pkt(2, 32'h52, 1);
        expect_pkt(3, 32'h53, 1);
        expect_pkt(0, 32'h54, 1);
        drive();
        drain("t5_cycle", 1'b0);

        // Half-full priority from rr_ptr=0 with queues 0 and 3 requesting.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.q_half_full[3] = 1'b1;
        load(0, 32'h60, 1);
        load(3, 32'h63, 1);
`ifdef ARB_HALF_FULL_PRIO_EN
        expect_pkt(3, 32'h63, 1);
        expect_pkt(0, 32'h60, 1);
`else
        expect_pkt(0, 32'h60, 1);
        expect_pkt(3, 32'h63, 1);
`endif
        drive();
        drain("t6_half_full", 1'b0);
        bus.q_half_full = '0;

        // Move rr_ptr to 2, then reset while queue 2 is mid-packet.
        load(1, 32'h71, 1);
        expect_pkt(1, 32'h71, 1);
        drive();
        drain("t7_prep", 1'b0);
        load(2, 32'h80, 4);
        expect_pkt(2, 32'h80, 4);
        drive();
        step();
        step();
        step();
        check("t7_busy", 64'(bus.busy), 64'd1);
        check("t7_grant", 64'(bus.grant_idx), 64'd2);
        bus.out_tready = 1'b0;
        rst = 1'b1;
        step();
        check("t7_rst_busy", 64'(bus.busy), 64'd0);
        check("t7_rst_in_tready", 64'(bus.in_tready), 64'd0);
        check("t7_rst_out_tvalid", 64'(bus.out_tvalid), 64'd0);
        check("t7_truncated_left", 64'(srcq[2].size()), 64'd2);
        void'(expq.pop_back());
        void'(expq.pop_back());
        srcq[2].delete();
        rst = 1'b0;
        bus.out_tready = 1'b1;
        load(1, 32'h91, 1);
        load(2, 32'h92, 1);
        expect_pkt(1, 32'h91, 1);
        expect_pkt(2, 32'h92, 1);
        drive();
        drain("t7_restart", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/queue_output_arbiter.md
Name: queue_output_arbiter

Overview:
- Shares one AXI-Stream output port of the cross router between NUM_IN input queues.
- Grants whole packets (TLAST-delimited) using round-robin order, so beats from different sources never interleave.
- Consumes the queues' empty/half_full status and drives per-queue TREADY.
- Sits between the per-input signalled queues and the router output link.

Parameters:
- NUM_IN, 4, number of requesting queues (≥2).
- DATA_WIDTH, 32, TDATA width per queue.
- IDX_W, $clog2(NUM_IN), grant index width (localparam, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_tvalid  in  NUM_IN  per-queue TVALID.
- in_tready  out  NUM_IN  per-queue TREADY.
- in_tdata  in  NUM_IN*DATA_WIDTH  queue i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_tlast  in  NUM_IN  per-queue TLAST.
- q_empty  in  NUM_IN  queue empty flags.
- q_half_full  in  NUM_IN  queue half_full flags.
- out_tvalid  out  1  output TVALID.
- out_tready  in  1  output TREADY.
- out_tdata  out  DATA_WIDTH  output TDATA.
- out_tlast  out  1  output TLAST.
- grant_idx  out  IDX_W  index of the currently granted queue.
- busy  out  1  high while a packet is locked.

Behaviour:
- One clock (clk); reset rst is synchronous, active-high.
- FSM states:
  - IDLE: no grant.
  - LOCK: grant held until the packet's last beat.
- Reset values:
  - state=IDLE, rr_ptr=0, grant_idx=0.
  - busy=0, in_tready=0, out_tvalid=0.
- Request vector: req[i] = in_tvalid[i] & ~q_empty[i].
- IDLE → LOCK:
  - Taken when any req is set.
  - grant_idx <= first set req at or after rr_ptr, searching upward and wrapping modulo NUM_IN.
  - Arbitration latency: 1 cycle. The first beat can transfer in the cycle after the request is seen.
- In LOCK, the datapath is a combinational pass-through:
  - out_tvalid = in_tvalid[grant_idx].
  - out_tdata and out_tlast come from the granted queue.
  - in_tready[grant_idx] = out_tready. All other in_tready are 0.
- LOCK → IDLE:
  - Taken on a beat with out_tvalid & out_tready & out_tlast.
  - rr_ptr <= grant_idx+1, wrapping to 0 after NUM_IN-1.
- LOCK with no beat, or a non-last beat: hold. The grant is never revoked mid-packet, even if the granted queue's TVALID drops.
- IDLE with no requests: everything holds, outputs stay 0.
- Single-beat packet (TLAST on the first beat): LOCK lasts exactly 1 cycle if out_tready=1.
- Back-to-back traffic: at least 1 IDLE cycle between packets (accepted bubble, keeps timing flat).
- busy = (state==LOCK).
- Reset mid-packet: return to IDLE immediately. The packet is truncated downstream; this is the caller's responsibility.

Optional Feature:
- Macro: ARB_HALF_FULL_PRIO_EN.
- Defined:
  - IDLE arbitration first searches hi_req = req & q_half_full, round-robin from rr_ptr.
  - Only if hi_req is zero does it fall back to the normal search over req.
  - The rr_ptr update is unchanged.
- Undefined: q_half_full is ignored (port kept, unused), and arbitration is pure round-robin.

Decomposition:
- Package router_arb_pkg holds:
  - the state enum typedef (IDLE, LOCK);
  - a function rr_pick(req, ptr) returning the index and a found flag.
- One natural sub-module: rr_priority_picker (combinational rotate + priority encode). It is instantiated twice when ARB_HALF_FULL_PRIO_EN is defined.

Test Plan:
- Reset with all in_tvalid=1 → in_tready=0, out_tvalid=0, busy=0. First grant goes to queue 0 in the cycle after rst drops.
- Queues 0 and 2 each hold a 3-beat packet, out_tready=1:
  - queue 0 beats 0xA0..A2 appear first, then 1 IDLE cycle, then queue 2 beats 0xC0..C2;
  - rr_ptr ends at 3.
- Queue 1 packet with in_tvalid dropped for 2 cycles mid-packet:
  - grant_idx stays 1 throughout;
  - queue 3 requesting meanwhile is not granted until after queue 1's TLAST.
- out_tready toggling 1/0 every cycle during a 4-beat packet → exactly 4 transfers, order preserved, no duplicate beats.
- All 4 queues requesting continuously with 1-beat packets → grants cycle 0,1,2,3,0.
- With ARB_HALF_FULL_PRIO_EN defined, rr_ptr=0, queues 0 and 3 requesting, q_half_full[3]=1 → queue 3 granted first. Without the macro, queue 0 is granted first.
- rst asserted while queue 2 is mid-packet → the next cycle shows busy=0 and all in_tready=0. After release, arbitration restarts from rr_ptr=0.
